// File: rtl/vga_frame_buffer.sv
// Single-port-write / single-port-read RGB444 frame store with a vblank-aligned
// capture FSM on the write side and a 1-cycle registered random-access read side.
module vga_frame_buffer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [11:0] s_pixel,
  input  logic        vblank,
  input  logic [7:0]  rd_row,
  input  logic [8:0]  rd_col,
  output logic [11:0] rd_pixel,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);

  localparam int                DEPTH = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_SOF, WRITE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              r_sync_err;
  logic [11:0]       r_mem [DEPTH];
  logic [11:0]       r_rd_data;
  logic              r_rd_vld;

  logic              w_beat;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_in_range;

  assign s_ready    = (r_state == WAIT_SOF) || (r_state == WRITE);
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;

  // In WAIT_SOF only the SOF beat is stored; any SOF beat restarts at address 0.
  assign w_beat  = s_valid & s_ready;
  assign w_we    = w_beat & ((r_state == WRITE) | s_sof);
  assign w_waddr = s_sof ? '0 : r_wr_addr;

  assign w_rd_in_range = ({24'd0, rd_row} < 32'(IMG_H)) && ({23'd0, rd_col} < 32'(IMG_W));
  assign w_rd_addr     = ADDR_W'(rd_row) * ADDR_W'(IMG_W) + ADDR_W'(rd_col);

  // Storage has no reset; reading and writing in one block gives read-before-write.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= s_pixel;
    if (w_rd_in_range)
      r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_vld <= 1'b0;
    else
      r_rd_vld <= w_rd_in_range;
  end

  assign rd_pixel = r_rd_vld ? r_rd_data : 12'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_req)
            r_state <= ARMED;
        end
        ARMED: begin
          if (vblank)
            r_state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (w_beat && s_sof) begin
            r_wr_addr <= ADDR_W'(1);
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          if (w_beat) begin
            if (s_sof) begin
              r_sync_err <= (r_wr_addr != '0);
              r_wr_addr  <= ADDR_W'(1);
            end else if (r_wr_addr == LAST) begin
              r_frame_done <= 1'b1;
              r_wr_addr    <= '0;
              r_state      <= IDLE;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Randomized directed bench for vga_frame_buffer on a reduced 40x24 image, checked
// against a frame-level reference model (pixel array indexed by beat count from SOF).
module tb_vga_frame_buffer;

  localparam int W  = 40;
  localparam int H  = 24;
  localparam int AW = 10;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [11:0] s_pixel;
  logic        vblank;
  logic [7:0]  rd_row;
  logic [8:0]  rd_col;
  logic [11:0] rd_pixel;
  logic        busy;
  logic        frame_done;
  logic        sync_err;

  vga_frame_buffer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_pixel    (s_pixel),
    .vblank     (vblank),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_pixel   (rd_pixel),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected image plus the capture status seen by the source.
  logic [11:0] refm  [N];
  bit          known [N];
  bit          m_ready = 0;
  bit          m_busy  = 0;
  bit          m_wait  = 0;
  int          m_addr  = 0;
  int          n_done  = 0;
  int          n_sync  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of write-side stimulus; the read port watches the address being written.
  task automatic drive(input bit v, input bit sof, input logic [11:0] pix);
    int          ra;
    logic [11:0] old;
    bit          chk_rd;
    bit          exp_done;
    bit          exp_sync;
    ra     = m_wait ? 0 : m_addr;
    rd_row = 8'(ra / W);
    rd_col = 9'(ra % W);
    chk_rd = known[ra];
    old    = refm[ra];
    s_valid = v;
    s_sof   = sof;
    s_pixel = pix;
    check("s_ready", {31'd0, s_ready}, {31'd0, m_ready});
    @(posedge clk); #1;
    exp_done = 0;
    exp_sync = 0;
    if (v && m_ready) begin
      if (sof) begin
        exp_sync = !m_wait;
        refm[0] = pix; known[0] = 1;
        m_addr = 1; m_wait = 0;
      end else if (!m_wait) begin
        refm[m_addr] = pix; known[m_addr] = 1;
        m_addr++;
        if (m_addr == N) begin
          exp_done = 1; m_ready = 0; m_busy = 0; m_addr = 0;
        end
      end
    end
    if (frame_done) n_done++;
    if (sync_err) n_sync++;
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    check("sync_err", {31'd0, sync_err}, {31'd0, exp_sync});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (chk_rd) check("rd_rbw", {20'd0, rd_pixel}, {20'd0, old});
  endtask

  // load_req, then vblank held low for `hold` cycles before rising.
  task automatic arm(input int hold);
    s_valid = 0; s_sof = 0; vblank = 0; load_req = 1;
    @(posedge clk); #1;
    load_req = 0; m_busy = 1;
    check("arm_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("armed_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
    end
    vblank = 1;
    @(posedge clk); #1;
    vblank = 0;
    m_ready = 1; m_wait = 1;
    check("vblank_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic rd(input int r, input int c);
    logic [11:0] exp;
    s_valid = 0;
    rd_row = 8'(r);
    rd_col = 9'(c);
    exp = (r < H && c < W) ? refm[r * W + c] : 12'd0;
    @(posedge clk); #1;
    check($sformatf("rd(%0d,%0d)", r, c), {20'd0, rd_pixel}, {20'd0, exp});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_sync"}, {31'd0, sync_err}, 32'd0);
    check({tag, "_rdpix"}, {20'd0, rd_pixel}, 32'd0);
  endtask

  initial begin
    int beats;
    int lr_at;
    bit first;
    for (int i = 0; i < N; i++) begin
      refm[i] = 12'd0;
      known[i] = 0;
    end
    rst_n = 0; load_req = 0; s_valid = 0; s_sof = 0; s_pixel = 0;
    vblank = 0; rd_row = 0; rd_col = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Idle: beats are refused, nothing stored.
    for (int i = 0; i < 4; i++) drive(1, 1, 12'hFFF);
    s_valid = 0;

    // Alignment then full frame with pixel = address.
    arm(100);
    drive(1, 0, 12'hABC);
    drive(1, 0, 12'h123);
    drive(1, 0, 12'h456);
    for (int i = 0; i < N; i++) drive(1, i == 0, 12'(i));
    s_valid = 0;
    check("full_done_count", n_done, 1);
    check("full_busy_after", {31'd0, busy}, 32'd0);
    rd(0, 0);
    check("first_word_is_sof", {20'd0, rd_pixel}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      int r, c;
      r = $urandom_range(H - 1, 0);
      c = $urandom_range(W - 1, 0);
      rd(r, c);
      check("formula", {20'd0, rd_pixel}, {20'd0, 12'(r * W + c)});
    end
    rd(H, 0);
    rd(0, W);
    rd(255, 511);
    rd(H - 1, W - 1);
    check("last_word", {20'd0, rd_pixel}, {20'd0, 12'(N - 1)});

    // Resync: second SOF at beat 300 of WRITE.
    n_done = 0; n_sync = 0; beats = 0;
    arm(5);
    for (int i = 0; i < 3 * N && m_busy; i++) begin
      drive(1, i == 0 || i == 300, 12'($urandom));
      beats++;
    end
    s_valid = 0;
    check("resync_timeout", {31'd0, busy}, 32'd0);
    check("resync_sync_count", n_sync, 1);
    check("resync_done_count", n_done, 1);
    check("resync_beats", beats, 300 + N);

    // Backpressure: 30% valid duty, a stray load_req mid-frame.
    n_done = 0; first = 1;
    lr_at = 200;
    arm(2);
    for (int i = 0; i < 20 * N && m_busy; i++) begin
      bit v;
      v = ($urandom_range(99, 0) < 30);
      load_req = (i == lr_at);
      drive(v, v && first, 12'($urandom));
      if (v) first = 0;
    end
    load_req = 0; s_valid = 0;
    check("bp_timeout", {31'd0, busy}, 32'd0);
    check("bp_done_count", n_done, 1);
    for (int a = 0; a < N; a += 7) rd(a / W, a % W);
    rd(H - 1, W - 1);

    // Reset in the middle of a frame.
    n_done = 0;
    arm(1);
    for (int i = 0; i < 500; i++) drive(1, i == 0, 12'($urandom));
    #2 rst_n = 0;
    #1;
    check_idle_outputs("midreset");
    m_ready = 0; m_busy = 0; m_wait = 0; m_addr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < N + 10; i++) drive(1, i == 0, 12'($urandom));
    s_valid = 0;
    check("midreset_no_done", n_done, 0);
    arm(3);
    for (int i = 0; i < N; i++) drive(1, i == 0, 12'(i) ^ 12'h5A5);
    s_valid = 0;
    check("after_reset_done", n_done, 1);
    rd(0, 0);
    rd(H / 2, W / 3);
    rd(H - 1, W - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
